// File: rtl/io_pkg.sv
// Shared IO address map, port widths and seven-segment glyph table.
package io_pkg;

  typedef logic [31:0] io_word_t;

  localparam io_word_t ADDR_LED       = 32'hFFFF_FC60;
  localparam io_word_t ADDR_SW        = 32'hFFFF_FC70;
  localparam io_word_t ADDR_BTN_LEVEL = 32'hFFFF_FC74;
  localparam io_word_t ADDR_BTN_PRESS = 32'hFFFF_FC78;
  localparam io_word_t ADDR_SEG       = 32'hFFFF_FC80;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 5;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      4'hF:    g = 8'h8E;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU IO bus between the processor (master) and io_responder (slave).
interface io_responder_if;
  logic        ioRead;
  logic        ioWrite;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;

  modport master (output ioRead, ioWrite, addr, w_data, input r_data);
  modport slave  (input ioRead, ioWrite, addr, w_data, output r_data);
endinterface

// File: rtl/io_debounce.sv
// Per-bit two-flop synchronizer with optional debounce filter.
// Filter is built only when DEBOUNCE_EN is defined; otherwise dout is the synchronizer output.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic sync1_r;
  logic sync2_r;

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_bad
    $error("io_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_r;
  logic          db_r;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      db_r  <= 1'b0;
    end else if (sync2_r != db_r) begin
      if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_r  <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign dout = db_r;
`else
  assign dout = sync2_r;
`endif

endmodule

// File: rtl/io_responder.sv
// Memory-mapped LED/switch/button/seven-segment responder for a CPU IO bus.
// Define DEBOUNCE_EN to add per-bit debounce filters to the switch and button inputs.
module io_responder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  io_responder_if.slave       bus,
  input  logic [NUM_SW-1:0]   sw,
  input  logic [NUM_BTN-1:0]  btn,
  output logic [15:0]         led,
  output logic [7:0]          seg_an,
  output logic [7:0]          seg_out
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_SW-1:0]  sw_db_s;
  logic [NUM_BTN-1:0] btn_db_s;
  logic [NUM_BTN-1:0] btn_db_d_r;
  logic [NUM_BTN-1:0] press_r;
  logic [NUM_BTN-1:0] rise_s;
  logic [15:0]        led_r;
  io_word_t           seg_reg_r;
  io_word_t           r_data_s;
  logic [SCW-1:0]     scan_cnt_r;
  logic [2:0]         digit_r;
  logic [2:0]         digit_nxt_s;
  logic               wrap_s;
  logic [7:0]         seg_an_r;
  logic [7:0]         seg_out_r;
  logic               wr_led_s;
  logic               wr_seg_s;
  logic               rd_press_s;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk), .rst_n (rst_n), .din (sw[i]), .dout (sw_db_s[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk), .rst_n (rst_n), .din (btn[i]), .dout (btn_db_s[i])
    );
  end

  assign wr_led_s   = bus.ioWrite && (bus.addr == ADDR_LED);
  assign wr_seg_s   = bus.ioWrite && (bus.addr == ADDR_SEG);
  assign rd_press_s = bus.ioRead  && (bus.addr == ADDR_BTN_PRESS);
  assign rise_s     = btn_db_s & ~btn_db_d_r;

  // CPU-visible registers; a fresh rising edge wins over a clearing read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r      <= 16'h0;
      seg_reg_r  <= 32'h0;
      btn_db_d_r <= '0;
      press_r    <= '0;
    end else begin
      if (wr_led_s) led_r <= bus.w_data[15:0];
      if (wr_seg_s) seg_reg_r <= bus.w_data;
      btn_db_d_r <= btn_db_s;
      press_r    <= (rd_press_s ? '0 : press_r) | rise_s;
    end
  end

  // Read mux over registered state
  always_comb begin
    r_data_s = 32'h0;
    if (bus.ioRead) begin
      case (bus.addr)
        ADDR_LED:       r_data_s = {16'h0, led_r};
        ADDR_SW:        r_data_s = {16'h0, sw_db_s};
        ADDR_BTN_LEVEL: r_data_s = {27'h0, btn_db_s};
        ADDR_BTN_PRESS: r_data_s = {27'h0, press_r};
        ADDR_SEG:       r_data_s = seg_reg_r;
        default:        r_data_s = 32'h0;
      endcase
    end else begin
      r_data_s = 32'h0;
    end
  end

  assign bus.r_data  = r_data_s;
  assign wrap_s      = (scan_cnt_r == SCW'(SCAN_DIV - 1));
  assign digit_nxt_s = wrap_s ? digit_r + 3'd1 : digit_r;

  // Display scan; outputs follow the digit being entered so the first edge drives digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
      digit_r    <= 3'd0;
      seg_an_r   <= 8'hFF;
      seg_out_r  <= 8'hFF;
    end else begin
      scan_cnt_r <= wrap_s ? '0 : scan_cnt_r + 1'b1;
      digit_r    <= digit_nxt_s;
      seg_an_r   <= ~(8'h01 << digit_nxt_s);
      seg_out_r  <= seg_glyph(seg_reg_r[{digit_nxt_s, 2'b00} +: 4]);
    end
  end

  assign led     = led_r;
  assign seg_an  = seg_an_r;
  assign seg_out = seg_out_r;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: vector table, randomized bus traffic against a
// register model, and hand-written button/switch/scan/reset sequences.
module tb_io_responder;

  localparam int DEB  = 4;
  localparam int SCAN = 2;
`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif
  localparam int SETTLE = LAT + 4;

  localparam logic [31:0] A_LED   = 32'hFFFF_FC60;
  localparam logic [31:0] A_SW    = 32'hFFFF_FC70;
  localparam logic [31:0] A_LEVEL = 32'hFFFF_FC74;
  localparam logic [31:0] A_PRESS = 32'hFFFF_FC78;
  localparam logic [31:0] A_SEG   = 32'hFFFF_FC80;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [4:0]  btn = 5'h0;
  logic [15:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;
  int          errors = 0;
  int          checks = 0;
  int unsigned n_edges;
  logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  vec_t        tbl [17];

  io_responder_if bif ();

  io_responder #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bif), .sw (sw), .btn (btn),
    .led (led), .seg_an (seg_an), .seg_out (seg_out)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was last released
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata);
    bif.ioWrite = wr;
    bif.ioRead  = rd;
    bif.addr    = a;
    bif.w_data  = d;
    @(negedge clk);
    rdata = bif.r_data;
    @(posedge clk);
    #1;
    bif.ioWrite = 1'b0;
    bif.ioRead  = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_op(1'b0, 1'b1, a, 32'h0, r);
    check(name, r, exp);
  endtask

  // Digit k is lit for SCAN edges; the first edge after reset lights digit 0
  task automatic check_scan(input logic [31:0] seg_val, input int n, input string tag);
    int d;
    logic [7:0] e_an, e_out;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (n_edges == 0) begin
        e_an  = 8'hFF;
        e_out = 8'hFF;
      end else begin
        d     = int'((n_edges / SCAN) % 8);
        e_an  = ~(8'h01 << d);
        e_out = glyph[seg_val[d*4 +: 4]];
      end
      check({tag, "_an"}, {24'h0, seg_an}, {24'h0, e_an});
      check({tag, "_out"}, {24'h0, seg_out}, {24'h0, e_out});
    end
  endtask

  initial begin
    logic [31:0] r, a, d;
    logic [15:0] led_m;
    logic [31:0] seg_m;
    int op;
    bit found;

    bif.ioRead = 1'b0; bif.ioWrite = 1'b0; bif.addr = 32'h0; bif.w_data = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {24'h0, seg_an}, 32'h0000_00FF);
    check("rst_out", {24'h0, seg_out}, 32'h0000_00FF);
    check("rst_led", {16'h0, led}, 32'h0);
    rst_n = 1'b1;
    check_scan(32'h0, 4, "first");
    @(posedge clk); #1;

    // Vector table
    tbl[0]  = '{1'b1, 1'b0, A_LED,   32'h0000_A5A5, 32'h0,          16'hA5A5};
    tbl[1]  = '{1'b0, 1'b1, A_LED,   32'h0,         32'h0000_A5A5, 16'hA5A5};
    tbl[2]  = '{1'b1, 1'b0, A_SEG,   32'h7654_3210, 32'h0,          16'hA5A5};
    tbl[3]  = '{1'b0, 1'b1, A_SEG,   32'h0,         32'h7654_3210, 16'hA5A5};
    tbl[4]  = '{1'b1, 1'b0, A_LED,   32'hFFFF_1234, 32'h0,          16'h1234};
    tbl[5]  = '{1'b0, 1'b1, A_LED,   32'h0,         32'h0000_1234, 16'h1234};
    tbl[6]  = '{1'b1, 1'b0, A_SW,    32'hDEAD_BEEF, 32'h0,          16'h1234};
    tbl[7]  = '{1'b0, 1'b1, A_SW,    32'h0,         32'h0,          16'h1234};
    tbl[8]  = '{1'b1, 1'b0, 32'hFFFF_FC64, 32'h0000_5555, 32'h0,   16'h1234};
    tbl[9]  = '{1'b0, 1'b1, A_LED,   32'h0,         32'h0000_1234, 16'h1234};
    tbl[10] = '{1'b0, 1'b1, 32'hFFFF_FC64, 32'h0,   32'h0,          16'h1234};
    tbl[11] = '{1'b0, 1'b1, A_LEVEL, 32'h0,         32'h0,          16'h1234};
    tbl[12] = '{1'b0, 1'b1, A_PRESS, 32'h0,         32'h0,          16'h1234};
    tbl[13] = '{1'b0, 1'b0, A_SEG,   32'h0,         32'h0,          16'h1234};
    tbl[14] = '{1'b0, 1'b1, 32'hFFFF_FC81, 32'h0,   32'h0,          16'h1234};
    tbl[15] = '{1'b1, 1'b0, A_LED,   32'h0000_A5A5, 32'h0,          16'hA5A5};
    tbl[16] = '{1'b0, 1'b1, A_LED,   32'h0,         32'h0000_A5A5, 16'hA5A5};
    for (int i = 0; i < 17; i++) begin
      bus_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, r);
      check($sformatf("vec%0d_rd", i), r, tbl[i].exp_rd);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
    end

    // Scan with SEG = 76543210 shows glyphs 0..7
    check_scan(32'h7654_3210, 24, "scan");
    @(posedge clk); #1;

    // Randomized bus traffic against a register model
    led_m = 16'hA5A5;
    seg_m = 32'h7654_3210;
    sw = 16'($urandom);
    cycles(SETTLE);
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 6));
      d  = $urandom;
      a  = 32'hFFFF_FC00 + 32'($urandom_range(0, 63) * 4);
      if (a == A_LED || a == A_SW || a == A_LEVEL || a == A_PRESS || a == A_SEG)
        a = 32'h0000_1000;
      case (op)
        0: begin bus_op(1'b1, 1'b0, A_LED, d, r); led_m = d[15:0]; end
        1: begin bus_op(1'b1, 1'b0, A_SEG, d, r); seg_m = d; end
        2: begin bus_op(1'b0, 1'b1, A_LED, 32'h0, r); check("rnd_led", r, {16'h0, led_m}); end
        3: begin bus_op(1'b0, 1'b1, A_SEG, 32'h0, r); check("rnd_seg", r, seg_m); end
        4: begin bus_op(1'b0, 1'b1, A_SW, 32'h0, r); check("rnd_sw", r, {16'h0, sw}); end
        5: begin bus_op(1'b0, 1'b1, a, 32'h0, r); check("rnd_unmapped", r, 32'h0); end
        default: bus_op(1'b1, 1'b0, a, d, r);
      endcase
      check("rnd_led_out", {16'h0, led}, {16'h0, led_m});
    end

    // Switch filtering / latency
    sw = 16'h0;
    cycles(SETTLE);
`ifdef DEBOUNCE_EN
    sw[0] = 1'b1; cycles(2); sw[0] = 1'b0; cycles(10);
    read_chk("sw_pulse", A_SW, 32'h0);
    sw[0] = 1'b1; cycles(3); sw[0] = 1'b0; cycles(1); sw[0] = 1'b1; cycles(3);
    read_chk("sw_glitch", A_SW, 32'h0);
    cycles(10);
    read_chk("sw_held", A_SW, 32'h1);
`else
    sw[0] = 1'b1; cycles(1);
    read_chk("sw_lat1", A_SW, 32'h0);
    read_chk("sw_lat2", A_SW, 32'h1);
`endif

    // Press then release, read-to-clear
    btn[2] = 1'b1; cycles(SETTLE);
    read_chk("btn_level", A_LEVEL, 32'h4);
    btn[2] = 1'b0; cycles(SETTLE);
    read_chk("press_first", A_PRESS, 32'h4);
    read_chk("press_cleared", A_PRESS, 32'h0);

    // Rising edge coincides with the clearing read
    btn[0] = 1'b1; cycles(SETTLE); btn[0] = 1'b0; cycles(SETTLE);
    btn[1] = 1'b1; cycles(LAT);
    read_chk("press_race_old", A_PRESS, 32'h1);
    read_chk("press_race_new", A_PRESS, 32'h2);
    btn[1] = 1'b0; cycles(SETTLE);
    read_chk("press_release", A_PRESS, 32'h0);

    // Reset mid-scan at digit 5
    btn[3] = 1'b1; cycles(SETTLE); btn[3] = 1'b0; cycles(SETTLE);
    bus_op(1'b1, 1'b0, A_LED, 32'h0000_BEEF, r);
    check("pre_rst_led", {16'h0, led}, 32'h0000_BEEF);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (((n_edges / SCAN) % 8) == 5) found = 1'b1;
    end
    check("digit5_reached", {31'h0, found}, 32'h1);
    check("digit5_an", {24'h0, seg_an}, 32'h0000_00DF);
    bif.ioRead = 1'b1; bif.addr = A_PRESS;
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", {24'h0, seg_an}, 32'h0000_00FF);
    check("mid_rst_out", {24'h0, seg_out}, 32'h0000_00FF);
    check("mid_rst_led", {16'h0, led}, 32'h0);
    check("mid_rst_press", bif.r_data, 32'h0);
    bif.ioRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_scan(32'h0, 8, "restart");
    @(posedge clk); #1;
    read_chk("post_rst_led", A_LED, 32'h0);
    read_chk("post_rst_seg", A_SEG, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, SHALL be the number of consecutive stable cycles required to accept a new input level.
REQ-002 Parameter SCAN_DIV, default 100000, SHALL be the number of clock cycles each seven-segment digit is lit.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ioRead  input  1  SHALL be the CPU IO read strobe, one cycle per access.
REQ-006 ioWrite  input  1  SHALL be the CPU IO write strobe, one cycle per access.
REQ-007 addr  input  32  SHALL be the IO byte address from the CPU.
REQ-008 w_data  input  32  SHALL be the CPU write data.
REQ-009 r_data  output  32  SHALL be the read data returned to the CPU.
REQ-010 sw  input  16  SHALL be the raw, asynchronous switch levels.
REQ-011 btn  input  5  SHALL be the raw, asynchronous button levels (1 = pressed).
REQ-012 led  output  16  SHALL be the LED drive (1 = on).
REQ-013 seg_an  output  8  SHALL be the active-low digit anodes.
REQ-014 seg_out  output  8  SHALL be the active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-015 Address map SHALL be: 0xFFFFFC60 LED (R/W), 0xFFFFFC70 SW (R), 0xFFFFFC74 BTN_LEVEL (R), 0xFFFFFC78 BTN_PRESS (R, read-to-clear), 0xFFFFFC80 SEG (R/W).
REQ-016 Write with ioWrite=1 to LED SHALL load w_data[15:0] into led at the same clock edge; to SEG SHALL load all 32 bits; writes to other addresses SHALL be ignored.
REQ-017 r_data SHALL be combinational from registered state, zero-extended: LED {16'h0,led}, SW {16'h0,sw_db}, BTN_LEVEL {27'h0,btn_db}, BTN_PRESS {27'h0,press}, SEG seg_reg; unmapped address or ioRead=0 SHALL give 32'h0.
REQ-018 Every sw and btn bit SHALL pass through a two-flop synchronizer before any other use.
REQ-019 press[i] SHALL set on the cycle after btn_db[i] rises 0->1 and remain set until cleared.
REQ-020 A cycle with ioRead=1 at BTN_PRESS SHALL return the current press bits and clear them at that clock edge.
REQ-021 A new rising edge coinciding with the clearing read SHALL leave that bit set.
REQ-022 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at each wrap the digit index SHALL advance 0->1->...->7->0.
REQ-023 For digit index k, seg_an SHALL be all ones except bit k = 0, and seg_out SHALL be the active-low hex glyph of seg_reg[4k+3:4k], dp off; both outputs registered.
REQ-024 A SEG write SHALL take effect on the next registered glyph update without resetting the scan counter.

Reset
REQ-025 While rst_n=0: led=0, seg_reg=0, press=0, sw_db=0, btn_db=0, synchronizers=0, scan counter=0, digit index=0, seg_an=8'hFF, seg_out=8'hFF.
REQ-026 After rst_n deasserts, the first registered glyph update SHALL occur on the first clock edge, driving digit 0; reset asserted mid-scan or mid-debounce SHALL discard all progress.

Configuration
REQ-027 With DEBOUNCE_EN defined, each synchronized input SHALL update its debounced value only after differing from it for DEBOUNCE_CYCLES consecutive cycles; a glitch SHALL restart the count.
REQ-028 Without DEBOUNCE_EN, debounced values SHALL equal the synchronizer outputs (2-cycle latency), and no debounce counters SHALL be instantiated.

Structure
REQ-029 The address constants and the seg glyph table SHALL live in shared package io_pkg.
REQ-030 The per-bit synchronizer plus debounce filter SHALL be sub-module io_debounce, instantiated 21 times.

Verification
REQ-031 After reset, write 0x0000A5A5 to 0xFFFFFC60 -> led=16'hA5A5 the next cycle; read returns 0x0000A5A5.
REQ-032 DEBOUNCE_EN, DEBOUNCE_CYCLES=4: sw[0] pulse of 2 cycles -> SW read stays 0; held 10 cycles -> SW read = 0x00000001.
REQ-033 btn[2] pressed then released, then read BTN_PRESS -> 0x00000004; an immediate second read -> 0x00000000.
REQ-034 btn[1] rising edge lands in the same cycle as a BTN_PRESS read -> the read returns old bits, and the following read returns 0x00000002.
REQ-035 SCAN_DIV=2, SEG=0x76543210 -> seg_an cycles FE,FD,...,7F,FE every 2 cycles; seg_out shows glyphs 0..7 (e.g. 8'hC0 for "0").
REQ-036 rst_n pulsed low mid-scan at digit 5 -> seg_an=8'hFF, led=0, press=0 immediately; scan restarts at digit 0.
